// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: FSM state encoding,
// segment patterns (bit6=a ... bit0=g, active-high) and digit-enable idle value.
package seg7_pkg;

    localparam logic [0:0] ST_DRIVE = 1'b0;
    localparam logic [0:0] ST_GAP   = 1'b1;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] AN_OFF = 4'hF;

endpackage

// File: rtl/Binary_7Segment.sv
// Combinational BCD to 7-segment decoder; non-BCD nibbles decode to blank.
module Binary_7Segment
    import seg7_pkg::*;
(
    input  logic [3:0] Binary_Num,
    output logic [6:0] Segment
);

    // Table lookup of the segment pattern for one nibble
    always_comb begin
        Segment = SEG_BLANK;
        case (Binary_Num)
            4'd0:    Segment = SEG_0;
            4'd1:    Segment = SEG_1;
            4'd2:    Segment = SEG_2;
            4'd3:    Segment = SEG_3;
            4'd4:    Segment = SEG_4;
            4'd5:    Segment = SEG_5;
            4'd6:    Segment = SEG_6;
            4'd7:    Segment = SEG_7;
            4'd8:    Segment = SEG_8;
            4'd9:    Segment = SEG_9;
            default: Segment = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a one-deep pending value
// register, frame-synchronous display update and leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIV  = 1000,
    parameter int unsigned DEAD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        lzb,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [15:0] DEAD_LAST = 16'(DEAD - 1);

    logic [0:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic        in_ready_q, in_ready_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        frame_done_q, frame_done_d;

    logic        frame_end;
    logic        accept;
    logic        blank;
    logic [3:0]  cur_nibble;
    logic [6:0]  dec_seg;

    assign accept     = in_valid && in_ready_q;
    assign cur_nibble = disp_q[{idx_q, 2'b00} +: 4];
    // Digit is a leading zero when it and every higher digit are zero
    assign blank      = lzb && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000);

    Binary_7Segment u_dec (
        .Binary_Num (cur_nibble),
        .Segment    (dec_seg)
    );

    // Scan FSM: DRIVE for DIV cycles, GAP for DEAD cycles, then next digit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        frame_end = 1'b0;
        if (!en) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == ST_DRIVE) begin
            if (cnt_q == DIV_LAST) begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            if (cnt_q == DEAD_LAST) begin
                state_d   = ST_DRIVE;
                cnt_d     = '0;
                idx_d     = idx_q + 2'd1;
                frame_end = (idx_q == 2'd3);
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Pending/display registers; in_ready tracks the next pend_v so it stays registered
    always_comb begin
        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (frame_end && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end
        if (accept) begin
            pend_d   = in_data;
            pend_v_d = 1'b1;
        end
        in_ready_d = !pend_v_d;
    end

    // Output stage: drive digit pattern during DRIVE, all off during GAP or when disabled
    always_comb begin
        seg_d        = SEG_BLANK;
        an_d         = AN_OFF;
        frame_done_d = frame_end;
        if (en && state_q == ST_DRIVE) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = blank ? SEG_BLANK : dec_seg;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_DRIVE;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            in_ready_q   <= in_ready_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign in_ready   = in_ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a timeline model predicts each cycle's
// outputs and queues them; a monitor pops and compares after every clock edge.
module tb_seg7_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEAD  = 2;
    localparam int unsigned SLOT  = DIV + DEAD;
    localparam int unsigned FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready;
    logic        lzb = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .lzb        (lzb),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   failures = 0;

    logic [6:0] seg_tab [16];
    initial begin
        seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    end

    // Reference model: time since scan start decides digit and phase
    int unsigned m_t = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_pv = 1'b0;

    always @(posedge clk) begin
        obs_t e;
        int unsigned pos, dig;
        logic fe, acc, lead;
        if (!rst_n) begin
            e = '{an: 4'hF, seg: 7'h00, fd: 1'b0, rdy: 1'b1};
            m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
        end else begin
            e.an = 4'hF; e.seg = 7'h00; fe = 1'b0;
            if (en) begin
                pos = m_t % FRAME;
                dig = pos / SLOT;
                if ((pos % SLOT) < DIV) begin
                    e.an = 4'hF & ~(4'h1 << dig);
                    lead = lzb && (dig > 0);
                    for (int unsigned k = dig; k < 4; k++)
                        if (m_disp[4*k +: 4] != 4'h0) lead = 1'b0;
                    e.seg = lead ? 7'h00 : seg_tab[m_disp[4*dig +: 4]];
                end
                fe = (pos == FRAME - 1);
            end
            acc = in_valid && !m_pv;
            if (fe && m_pv) begin m_disp = m_pend; m_pv = 1'b0; end
            if (acc) begin m_pend = in_data; m_pv = 1'b1; end
            m_t = en ? m_t + 1 : 0;
            e.fd = fe;
            e.rdy = !m_pv;
        end
        q.push_back(e);
    end

    // Monitor: compare DUT outputs against the queued prediction
    always @(posedge clk) begin
        obs_t e, a;
        #2;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=none exp=entry t=%0t", $time);
        end else begin
            e = q.pop_front();
            a = '{an: an, seg: seg, fd: frame_done, rdy: in_ready};
            if (a !== e) begin
                failures++;
                if (failures <= 40)
                    $display("FAIL cycle_out t=%0t got an=%h seg=%h fd=%b rdy=%b exp an=%h seg=%h fd=%b rdy=%b",
                             $time, a.an, a.seg, a.fd, a.rdy, e.an, e.seg, e.fd, e.rdy);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a value and hold in_valid until the handshake completes (bounded)
    task automatic offer(input logic [15:0] d);
        logic r;
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300; i++) begin
            r = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL offer_timeout got=not_accepted exp=accepted data=%h", d);
        end
    endtask

    // Asynchronous reset pulse with an immediate, clock-free check
    task automatic reset_pulse();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h00 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got an=%h seg=%h fd=%b rdy=%b exp an=f seg=00 fd=0 rdy=1",
                     an, seg, frame_done, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        run(3);
        rst_n = 1'b1;
        en = 1'b1;
        run(60);
        offer(16'h1234);
        run(60);
        offer(16'h5678);
        offer(16'h9999);
        run(60);
        lzb = 1'b1;
        offer(16'h0070);
        run(60);
        offer(16'h0000);
        run(60);
        lzb = 1'b0;
        offer(16'h00C0);
        run(40);
        offer(16'h4321);
        run(3);
        reset_pulse();
        run(40);
        run(9);
        en = 1'b0;
        run(7);
        offer(16'h2468);
        en = 1'b1;
        run(60);
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 16'($urandom);
            if ($urandom_range(0, 30) == 0) lzb = ~lzb;
            if ($urandom_range(0, 60) == 0) en = ~en;
            if ($urandom_range(0, 400) == 0) reset_pulse();
            else @(negedge clk);
        end
        in_valid = 1'b0;
        en = 1'b1;
        run(30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
